// File: rtl/video_timing_if.sv
// Raster-scan bundle between the timing generator and its consumers.
// The pixel enable flows in and the decoded position flows out.
interface video_timing_if;
    logic        i_ce;
    logic [10:0] o_hcnt;
    logic [10:0] o_vcnt;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic        o_line_start;
    logic        o_frame_start;
    logic [15:0] o_frame_cnt;

    modport master (
        input  i_ce,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
               o_line_start, o_frame_start, o_frame_cnt
    );

    modport slave (
        output i_ce,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
               o_line_start, o_frame_start, o_frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster counter decoded into sync, data-enable and frame/line pulses.
// All outputs are registered together, so they describe the same pixel each cycle.
module video_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    video_timing_if.master vt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

    logic [10:0] h_reg, v_reg;
    logic [15:0] f_reg;
    logic [10:0] h_next, v_next;
    logic [15:0] f_next;
    logic        h_last, v_last;
    logic        de_next, hs_on, vs_on;

    always_comb begin
        h_last  = (h_reg == H_LAST);
        v_last  = (v_reg == V_LAST);
        h_next  = h_last ? 11'd0 : h_reg + 11'd1;
        v_next  = v_reg;
        f_next  = f_reg;
        if (h_last) begin
            v_next = v_last ? 11'd0 : v_reg + 11'd1;
            if (v_last) begin
                f_next = f_reg + 16'd1;
            end
        end
        de_next = (h_reg < H_ACT_W) && (v_reg < V_ACT_W);
        hs_on   = (h_reg >= HS_START) && (h_reg < HS_END);
        vs_on   = (v_reg >= VS_START) && (v_reg < VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_reg            <= 11'd0;
            v_reg            <= 11'd0;
            f_reg            <= 16'd0;
            vt.o_hcnt        <= 11'd0;
            vt.o_vcnt        <= 11'd0;
            vt.o_hsync       <= ~HSYNC_POL;
            vt.o_vsync       <= ~VSYNC_POL;
            vt.o_de          <= 1'b0;
            vt.o_line_start  <= 1'b0;
            vt.o_frame_start <= 1'b0;
            vt.o_frame_cnt   <= 16'd0;
        end else if (vt.i_ce) begin
            // Outputs take the position being emitted; counters then move on.
            vt.o_hcnt        <= h_reg;
            vt.o_vcnt        <= v_reg;
            vt.o_hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vt.o_vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            vt.o_de          <= de_next;
            vt.o_line_start  <= (h_reg == 11'd0);
            vt.o_frame_start <= (h_reg == 11'd0) && (v_reg == 11'd0);
            vt.o_frame_cnt   <= f_reg;
            h_reg            <= h_next;
            v_reg            <= v_next;
            f_reg            <= f_next;
        end else begin
            // Pulses stay one clk wide however sparse the pixel enable is.
            vt.o_line_start  <= 1'b0;
            vt.o_frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a linear-index raster model predicts every output cycle,
// a separate monitor compares the DUT against the queued predictions.
module tb_video_timing_gen;
    localparam int HA = 20, HF = 4, HS = 6, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b0;

    typedef struct packed {
        logic [10:0] hcnt;
        logic [10:0] vcnt;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    video_timing_if vt();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vt    (vt.master)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t cur;
    int   pos;          // linear raster index of the next pixel: v*HT + h
    int   frame;
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    // Reference: advance a linear pixel index and derive (h,v) from it.
    task automatic step(input bit rst, input bit ce);
        int h, v;
        @(negedge clk);
        reset   = rst;
        vt.i_ce = ce;
        if (rst) begin
            pos = 0;
            frame = 0;
            cur = '{hcnt: 0, vcnt: 0, hs: ~HPOL, vs: ~VPOL, de: 0, ls: 0, fs: 0, fc: 0};
        end else if (ce) begin
            h = pos % HT;
            v = pos / HT;
            cur.hcnt = 11'(h);
            cur.vcnt = 11'(v);
            cur.de   = (h < HA) && (v < VA);
            cur.hs   = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
            cur.vs   = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
            cur.ls   = (h == 0);
            cur.fs   = (pos == 0);
            cur.fc   = 16'(frame);
            pos = pos + 1;
            if (pos == HT * VT) begin
                pos = 0;
                frame = (frame + 1) % 65536;
            end
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
        end
        exp_q.push_back(cur);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a new output state every clk.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hcnt",        32'(vt.o_hcnt),        32'(e.hcnt));
                chk("vcnt",        32'(vt.o_vcnt),        32'(e.vcnt));
                chk("hsync",       32'(vt.o_hsync),       32'(e.hs));
                chk("vsync",       32'(vt.o_vsync),       32'(e.vs));
                chk("de",          32'(vt.o_de),          32'(e.de));
                chk("line_start",  32'(vt.o_line_start),  32'(e.ls));
                chk("frame_start", 32'(vt.o_frame_start), 32'(e.fs));
                chk("frame_cnt",   32'(vt.o_frame_cnt),   32'(e.fc));
                $display("txn t=%0t h=%0d v=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                         $time, vt.o_hcnt, vt.o_vcnt, vt.o_de, vt.o_hsync, vt.o_vsync,
                         vt.o_line_start, vt.o_frame_start, vt.o_frame_cnt);
            end
        end
    end

    initial begin
        int budget;
        reset   = 1'b1;
        vt.i_ce = 1'b0;
        pos = 0;
        frame = 0;
        cur = '0;
        // Reset state, including reset winning over a simultaneous enable.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        // Continuous enable across two full frames plus a bit.
        for (int i = 0; i < 2 * HT * VT + 40; i++) step(1'b0, 1'b1);
        // Alternating enable for more than a frame.
        for (int i = 0; i < 2 * HT * VT + 60; i++) step(1'b0, 1'(i % 2 == 0));
        // Reset in the middle of the hsync region of a visible line.
        budget = 0;
        while (!(pos % HT == HA + HF + 2 && pos / HT == 3) && budget < 2 * HT * VT) begin
            step(1'b0, 1'b1);
            budget++;
        end
        chk("reach_hsync_region", 32'(budget < 2 * HT * VT), 32'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3 * HT; i++) step(1'b0, 1'b1);
        // Random enable with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end
        // Let the monitor drain the scoreboard.
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
